spi_bus_arbiter: RTL and testbench
==================================

SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: minimum cycles with spi_select high between any two grants (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum cycles one grant may be held (range 16..65535).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req  in  2  per-requester bus request; bit 0 = CPU, bit 1 = loader/debug.
REQ-007 req_select  in  2  per-requester active-low SPI chip select.
REQ-008 req_mosi  in  2  per-requester SPI data out.
REQ-009 req_clk_en  in  2  per-requester SPI clock enable.
REQ-010 spi_miso  in  1  shared SPI data in, already negedge-buffered upstream.
REQ-011 err_clr  in  1  clears timeout_err.
REQ-012 gnt  out  2  one-hot-or-zero grant, registered.
REQ-013 spi_select  out  1  shared chip select, active-low.
REQ-014 spi_mosi  out  1  shared SPI data out.
REQ-015 spi_clk_enable  out  1  shared SPI clock enable.
REQ-016 rsp_miso  out  2  spi_miso routed to the granted requester; 0 to the other.
REQ-017 timeout_err  out  1  sticky flag: a grant was revoked by timeout.

Function
REQ-018 SHALL implement states IDLE, OWN, GAP; owner index held in a register.
REQ-019 IDLE: if any eligible req bit is high at edge N, gnt SHALL be asserted from edge N+1; state moves to OWN.
REQ-020 Tie (both eligible): SHALL grant the requester that is not last_owner; last_owner resets to 1, so requester 0 wins the first tie.
REQ-021 OWN: spi_select/spi_mosi/spi_clk_enable SHALL be a combinational mux of the owner's req_select/req_mosi/req_clk_en; rsp_miso[owner] = spi_miso.
REQ-022 When not in OWN: spi_select=1, spi_mosi=0, spi_clk_enable=0, gnt=0, rsp_miso=0.
REQ-023 OWN ends when req[owner] is sampled low. At the next edge: gnt=0, last_owner=owner, state=GAP. The other requester's request does not pre-empt.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, then evaluate as IDLE in the same cycle. Minimum req-drop-to-next-gnt spacing is therefore GAP_CYCLES+1 edges.
REQ-025 Timeout counter SHALL clear on grant and increment each OWN cycle. On reaching TIMEOUT_CYCLES-1 with req[owner] still high, it SHALL revoke at the next edge: gnt=0, state=GAP, timeout_err=1, blocked[owner]=1.
REQ-026 Timeout counter width SHALL be 16 bits, saturating; no wrap-around is permitted.
REQ-027 blocked[i] makes requester i ineligible. It SHALL clear on the first edge where req[i] is sampled low.
REQ-028 err_clr and a timeout event in the same cycle: set SHALL win.
REQ-029 req dropping on the exact timeout cycle SHALL be treated as a normal release: no error, no block.
REQ-030 Requesters SHALL return their select high before dropping req. The arbiter forces spi_select=1 regardless on leaving OWN.

Reset
REQ-031 rst SHALL force, at the next edge: state=IDLE, gnt=0, last_owner=1, blocked=0, counters=0, timeout_err=0.
REQ-032 Consequently, on reset: spi_select=1, spi_mosi=0, spi_clk_enable=0, rsp_miso=0.
REQ-033 rst asserted mid-transaction SHALL abort immediately, with no GAP period enforced. The first grant after reset MAY occur on the edge after rst deasserts.

Structure
REQ-034 Package spi_arb_pkg SHALL hold the state enum, NUM_REQ=2, and the REQ_CPU/REQ_LOADER index constants.
REQ-035 One sub-module, spi_arb_timer, SHALL provide the shared counter used for both GAP counting and timeout: load/clear, enable, terminal-count output.
REQ-036 No other sub-modules.

Verification (GAP_CYCLES=2, TIMEOUT_CYCLES=16)
REQ-037 req=01 at edge 5 -> gnt=01 from edge 6; spi_select follows req_select[0]. Drop req edge 20 -> gnt=00 edge 21; spi_select=1 for edges 21-22.
REQ-038 req=11 from reset release -> gnt=01 first. Release -> gnt=10 exactly 3 edges later. Release -> gnt=01 again (round-robin).
REQ-039 req[1] held 20 cycles -> gnt revoked 16 edges after grant; timeout_err=1. Requester 1 is not regranted while req[1] stays high; req[0] is granted after GAP. Pulse req[1] low then high -> eligible again.
REQ-040 err_clr=1 on the same cycle as a timeout -> timeout_err=1. err_clr on a later cycle -> 0.
REQ-041 rst=1 while gnt=10 with spi_clk_enable=1 -> next edge: gnt=00, spi_select=1, spi_clk_enable=0, timeout_err=0.
REQ-042 While gnt=01: spi_miso toggling -> rsp_miso[0] mirrors it, rsp_miso[1]=0 throughout.

Source files
------------

// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the two-master SPI bus arbiter.
// Requester 0 is the CPU, requester 1 the loader/debug port.
package spi_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int REQ_CPU    = 0;
  localparam int REQ_LOADER = 1;
  localparam int TMR_W      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

// File: rtl/spi_arb_timer.sv
// Shared saturating up-counter for GAP spacing and grant timeout.
// tc is high while the count equals tc_val.
module spi_arb_timer
  import spi_arb_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc = (cnt == tc_val);

endmodule

// File: rtl/spi_bus_arbiter.sv
// Two-requester SPI bus arbiter: round-robin grant, enforced deselect
// gap between owners, and timeout revocation with per-requester block.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] req_select,
  input  logic [NUM_REQ-1:0] req_mosi,
  input  logic [NUM_REQ-1:0] req_clk_en,
  input  logic               spi_miso,
  input  logic               err_clr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               spi_select,
  output logic               spi_mosi,
  output logic               spi_clk_enable,
  output logic [NUM_REQ-1:0] rsp_miso,
  output logic               timeout_err
);

  localparam logic [TMR_W-1:0] GAP_TC = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_TC  = TMR_W'(TIMEOUT_CYCLES - 1);

  state_e             state;
  logic               owner;
  logic               last_owner;
  logic [NUM_REQ-1:0] blocked;

  logic [NUM_REQ-1:0] elig;
  logic               any_elig;
  logic               pick;
  logic               own_req;
  logic               tmr_tc;
  logic               rel_ev;
  logic               to_ev;
  logic               gnt_ev;

  assign elig     = req & ~blocked;
  assign any_elig = |elig;
  assign pick     = (&elig) ? ~last_owner : elig[REQ_LOADER];
  assign own_req  = req[owner];

  assign rel_ev = (state == ST_OWN) && !own_req;
  // A drop on the terminal cycle wins over the timeout.
  assign to_ev  = (state == ST_OWN) && own_req && tmr_tc;
  assign gnt_ev = any_elig &&
                  ((state == ST_IDLE) ||
                   ((state == ST_GAP) && tmr_tc));

  spi_arb_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (gnt_ev || rel_ev || to_ev),
    .en     (state != ST_IDLE),
    .tc_val ((state == ST_OWN) ? TO_TC : GAP_TC),
    .tc     (tmr_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt        <= '0;
    end else if (gnt_ev) begin
      state      <= ST_OWN;
      owner      <= pick;
      gnt        <= pick ? 2'b10 : 2'b01;
    end else if (rel_ev || to_ev) begin
      state      <= ST_GAP;
      last_owner <= owner;
      gnt        <= '0;
    end else if ((state == ST_GAP) && tmr_tc) begin
      state      <= ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blocked <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req[i]) begin
          blocked[i] <= 1'b0;
        end else if (to_ev && (owner == 1'(i))) begin
          blocked[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (to_ev) begin
      timeout_err <= 1'b1;
    end else if (err_clr) begin
      timeout_err <= 1'b0;
    end
  end

  always_comb begin
    spi_select     = 1'b1;
    spi_mosi       = 1'b0;
    spi_clk_enable = 1'b0;
    if (state == ST_OWN) begin
      spi_select     = req_select[owner];
      spi_mosi       = req_mosi[owner];
      spi_clk_enable = req_clk_en[owner];
    end
  end

  assign rsp_miso = gnt & {NUM_REQ{spi_miso}};

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with GAP_CYCLES=2, TIMEOUT_CYCLES=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_spi_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] req_select;
  logic [1:0] req_mosi;
  logic [1:0] req_clk_en;
  logic       spi_miso;
  logic       err_clr;
  logic [1:0] gnt;
  logic       spi_select;
  logic       spi_mosi;
  logic       spi_clk_enable;
  logic [1:0] rsp_miso;
  logic       timeout_err;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  spi_bus_arbiter #(
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_select     (req_select),
    .req_mosi       (req_mosi),
    .req_clk_en     (req_clk_en),
    .spi_miso       (spi_miso),
    .err_clr        (err_clr),
    .gnt            (gnt),
    .spi_select     (spi_select),
    .spi_mosi       (spi_mosi),
    .spi_clk_enable (spi_clk_enable),
    .rsp_miso       (rsp_miso),
    .timeout_err    (timeout_err)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req        = 2'b00;
    req_select = 2'b11;
    req_mosi   = 2'b00;
    req_clk_en = 2'b00;
    spi_miso   = 1'b0;
    err_clr    = 1'b0;
    step(2);
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_sel", 16'(spi_select), 16'h1);
    chk("rst_mosi", 16'(spi_mosi), 16'h0);
    chk("rst_clken", 16'(spi_clk_enable), 16'h0);
    chk("rst_rsp", 16'(rsp_miso), 16'h0);
    chk("rst_terr", 16'(timeout_err), 16'h0);

    // single CPU transaction
    rst        = 1'b0;
    req        = 2'b01;
    req_select = 2'b10;
    req_mosi   = 2'b01;
    req_clk_en = 2'b01;
    step(1);
    chk("t1_gnt", 16'(gnt), 16'h1);
    chk("t1_sel", 16'(spi_select), 16'h0);
    chk("t1_mosi", 16'(spi_mosi), 16'h1);
    chk("t1_clken", 16'(spi_clk_enable), 16'h1);
    req_select = 2'b11;
    #1 chk("t1_sel_follow", 16'(spi_select), 16'h1);
    req_select = 2'b10;
    spi_miso = 1'b1;
    #1 chk("t1_miso_hi", 16'(rsp_miso), 16'h1);
    spi_miso = 1'b0;
    #1 chk("t1_miso_lo", 16'(rsp_miso), 16'h0);
    spi_miso = 1'b1;
    #1 chk("t1_miso_hi2", 16'(rsp_miso), 16'h1);
    spi_miso = 1'b0;
    step(4);
    chk("t1_hold", 16'(gnt), 16'h1);
    req        = 2'b00;
    req_select = 2'b11;
    req_mosi   = 2'b00;
    req_clk_en = 2'b00;
    step(1);
    chk("t1_rel_gnt", 16'(gnt), 16'h0);
    chk("t1_rel_sel", 16'(spi_select), 16'h1);
    step(1);
    chk("t1_gap_sel", 16'(spi_select), 16'h1);
    step(2);

    // round robin from reset
    rst = 1'b1;
    step(1);
    rst        = 1'b0;
    req        = 2'b11;
    req_select = 2'b00;
    step(1);
    chk("rr_first", 16'(gnt), 16'h1);
    req = 2'b10;
    step(1);
    chk("rr_gap0", 16'(gnt), 16'h0);
    step(1);
    chk("rr_gap1", 16'(gnt), 16'h0);
    step(1);
    chk("rr_second", 16'(gnt), 16'h2);
    req = 2'b11;
    step(2);
    chk("rr_no_preempt", 16'(gnt), 16'h2);
    req = 2'b01;
    step(2);
    chk("rr_gap2", 16'(gnt), 16'h0);
    step(1);
    chk("rr_third", 16'(gnt), 16'h1);
    req = 2'b00;
    step(3);

    // loader timeout with err_clr on the same cycle
    req = 2'b10;
    step(1);
    chk("to_gnt", 16'(gnt), 16'h2);
    step(15);
    chk("to_pre_gnt", 16'(gnt), 16'h2);
    chk("to_pre_terr", 16'(timeout_err), 16'h0);
    err_clr = 1'b1;
    step(1);
    chk("to_revoke", 16'(gnt), 16'h0);
    chk("to_terr_set_wins", 16'(timeout_err), 16'h1);
    err_clr = 1'b0;
    step(5);
    chk("to_blocked", 16'(gnt), 16'h0);
    req = 2'b11;
    step(1);
    chk("to_cpu_gnt", 16'(gnt), 16'h1);
    req = 2'b10;
    step(3);
    chk("to_still_blocked", 16'(gnt), 16'h0);
    req = 2'b00;
    step(1);
    req = 2'b10;
    step(1);
    chk("to_unblocked", 16'(gnt), 16'h2);

    // reset mid-transaction
    req_select = 2'b01;
    req_clk_en = 2'b10;
    #1 chk("mr_clken_pre", 16'(spi_clk_enable), 16'h1);
    chk("mr_terr_pre", 16'(timeout_err), 16'h1);
    rst = 1'b1;
    step(1);
    chk("mr_gnt", 16'(gnt), 16'h0);
    chk("mr_sel", 16'(spi_select), 16'h1);
    chk("mr_clken", 16'(spi_clk_enable), 16'h0);
    chk("mr_terr", 16'(timeout_err), 16'h0);
    rst        = 1'b0;
    req        = 2'b00;
    req_select = 2'b11;
    req_clk_en = 2'b00;
    step(1);

    // drop exactly on the terminal cycle: normal release
    req = 2'b01;
    step(1);
    chk("ed_gnt", 16'(gnt), 16'h1);
    step(15);
    req = 2'b00;
    step(1);
    chk("ed_rel", 16'(gnt), 16'h0);
    chk("ed_terr", 16'(timeout_err), 16'h0);
    req = 2'b01;
    step(1);
    chk("ed_gap", 16'(gnt), 16'h0);
    step(1);
    chk("ed_regnt", 16'(gnt), 16'h1);

    // CPU timeout, then a later err_clr
    step(15);
    chk("c_pre", 16'(gnt), 16'h1);
    step(1);
    chk("c_revoke", 16'(gnt), 16'h0);
    chk("c_terr", 16'(timeout_err), 16'h1);
    err_clr = 1'b1;
    step(1);
    chk("c_clr", 16'(timeout_err), 16'h0);
    err_clr = 1'b0;
    req     = 2'b00;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
